comparator_8bit: RTL and testbench

COMPARATOR_8BIT -- requirements
Module: comparator_8bit

---
 rtl/comparator_8bit_pkg.sv | 12 +
 rtl/cmp_slice.sv | 29 ++
 rtl/comparator_8bit.sv | 57 +++++
 tb/tb_comparator_8bit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/comparator_8bit_pkg.sv
// Constants shared by the comparator top, its slices and anything binding to them.
// The result encoding is ordered {V3, V2, V1} = {gt, eq, lt}.
package comparator_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int SLICE_WIDTH   = 4;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/cmp_slice.sv
// One 4-bit unsigned magnitude comparator stage with cascade inputs.
// A decision already made by a more significant stage passes straight through.
module cmp_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       gt_in,
    input  logic       eq_in,
    input  logic       lt_in,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (gt_in) begin
            gt = 1'b1;
        end else if (lt_in) begin
            lt = 1'b1;
        end else if (eq_in) begin
            gt = (a > b);
            lt = (a < b);
            eq = (a == b);
        end
    end

endmodule

// File: rtl/comparator_8bit.sv
// Registered magnitude comparator: a chain of 4-bit slices, MSB first, feeding one
// output register. en is a plain load enable (no handshake); rst overrides it.
module comparator_8bit
    import comparator_8bit_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,  // must be a multiple of SLICE_WIDTH
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             V3,
    output logic             V2,
    output logic             V1
);

    localparam int NSLICE = WIDTH / SLICE_WIDTH;

    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] b_m;
    logic [NSLICE:0]  gt_c;
    logic [NSLICE:0]  eq_c;
    logic [NSLICE:0]  lt_c;

    // Flipping both sign bits maps two's complement order onto unsigned order.
    assign a_m = a ^ {(SIGNED != 0), {(WIDTH-1){1'b0}}};
    assign b_m = b ^ {(SIGNED != 0), {(WIDTH-1){1'b0}}};

    assign gt_c[0] = 1'b0;
    assign eq_c[0] = 1'b1;
    assign lt_c[0] = 1'b0;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        cmp_slice u_slice (
            .a     (a_m[WIDTH-1-SLICE_WIDTH*i -: SLICE_WIDTH]),
            .b     (b_m[WIDTH-1-SLICE_WIDTH*i -: SLICE_WIDTH]),
            .gt_in (gt_c[i]),
            .eq_in (eq_c[i]),
            .lt_in (lt_c[i]),
            .gt    (gt_c[i+1]),
            .eq    (eq_c[i+1]),
            .lt    (lt_c[i+1])
        );
    end

    // Reset state stands for the compare of 0 with 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            {V3, V2, V1} <= RES_EQ;
        end else if (en) begin
            {V3, V2, V1} <= {gt_c[NSLICE], eq_c[NSLICE], lt_c[NSLICE]};
        end
    end

endmodule

// File: tb/tb_comparator_8bit.sv
// Bench for comparator_8bit: one unsigned and one signed instance share the stimulus
// and are compared each cycle against an integer-arithmetic reference model.
module tb_comparator_8bit;
    import comparator_8bit_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic       u_v3, u_v2, u_v1;
    logic       s_v3, s_v2, s_v1;

    logic [2:0] exp_u;
    logic [2:0] exp_s;
    int         n_tests;
    int         n_fail;

    comparator_8bit #(.WIDTH(8), .SIGNED(0)) u_uns (
        .clk (clk), .rst (rst), .en (en), .a (a), .b (b),
        .V3  (u_v3), .V2 (u_v2), .V1 (u_v1)
    );

    comparator_8bit #(.WIDTH(8), .SIGNED(1)) u_sgn (
        .clk (clk), .rst (rst), .en (en), .a (a), .b (b),
        .V3  (s_v3), .V2 (s_v2), .V1 (s_v1)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        int vx;
        int vy;
        vx = int'(x);
        vy = int'(y);
        if (sgn) begin
            if (vx >= 128) vx = vx - 256;
            if (vy >= 128) vy = vy - 256;
        end
        if (vx > vy) return RES_GT;
        if (vx < vy) return RES_LT;
        return RES_EQ;
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, expv);
        end
    endtask

    // Drive one cycle, update the model at the edge, return 1 time unit after it.
    task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic nen, input logic nrst);
        a   = na;
        b   = nb;
        en  = nen;
        rst = nrst;
        @(posedge clk);
        if (nrst) begin
            exp_u = RES_EQ;
            exp_s = RES_EQ;
        end else if (nen) begin
            exp_u = ref_cmp(na, nb, 1'b0);
            exp_s = ref_cmp(na, nb, 1'b1);
        end
        #1;
    endtask

    task automatic check_both(input string tag);
        check({tag, "_u"}, {u_v3, u_v2, u_v1}, exp_u);
        check({tag, "_s"}, {s_v3, s_v2, s_v1}, exp_s);
    endtask

    logic [7:0] seq_a [5] = '{8'd0, 8'd8, 8'd100, 8'd64, 8'd32};
    logic [7:0] seq_b [5] = '{8'd0, 8'd7, 8'd120, 8'd78, 8'd32};
    logic [2:0] seq_e [5] = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b010};
    logic [7:0] edge_v [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        exp_u = RES_EQ;
        exp_s = RES_EQ;

        // reset then idle
        step(8'd5, 8'd9, 1'b1, 1'b1);
        step(8'd5, 8'd9, 1'b1, 1'b1);
        check("reset_u", {u_v3, u_v2, u_v1}, 3'b010);
        check("reset_s", {s_v3, s_v2, s_v1}, 3'b010);
        step(8'd200, 8'd3, 1'b0, 1'b0);
        step(8'd1, 8'd250, 1'b0, 1'b0);
        check("idle_hold_u", {u_v3, u_v2, u_v1}, 3'b010);
        check("idle_hold_s", {s_v3, s_v2, s_v1}, 3'b010);

        // back-to-back unsigned sequence
        for (int i = 0; i < 5; i++) begin
            step(seq_a[i], seq_b[i], 1'b1, 1'b0);
            check($sformatf("seq%0d", i), {u_v3, u_v2, u_v1}, seq_e[i]);
        end

        // unsigned extremes
        step(8'd255, 8'd0, 1'b1, 1'b0);   check("u_ff_00", {u_v3, u_v2, u_v1}, 3'b100);
        step(8'd0, 8'd255, 1'b1, 1'b0);   check("u_00_ff", {u_v3, u_v2, u_v1}, 3'b001);
        step(8'd128, 8'd127, 1'b1, 1'b0); check("u_80_7f", {u_v3, u_v2, u_v1}, 3'b100);
        step(8'd255, 8'd255, 1'b1, 1'b0); check("u_ff_ff", {u_v3, u_v2, u_v1}, 3'b010);

        // signed extremes
        step(8'hFF, 8'h00, 1'b1, 1'b0); check("s_ff_00", {s_v3, s_v2, s_v1}, 3'b001);
        step(8'h80, 8'h7F, 1'b1, 1'b0); check("s_80_7f", {s_v3, s_v2, s_v1}, 3'b001);
        step(8'h7F, 8'h80, 1'b1, 1'b0); check("s_7f_80", {s_v3, s_v2, s_v1}, 3'b100);
        step(8'h80, 8'h80, 1'b1, 1'b0); check("s_80_80", {s_v3, s_v2, s_v1}, 3'b010);

        // all boundary pairs in both modes
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                step(edge_v[i], edge_v[j], 1'b1, 1'b0);
                check_both($sformatf("edge_%0d_%0d", i, j));
            end
        end

        // enable and reset interaction
        step(8'd8, 8'd7, 1'b1, 1'b0); check("er_load", {u_v3, u_v2, u_v1}, 3'b100);
        step(8'd1, 8'd2, 1'b0, 1'b0); check("er_hold", {u_v3, u_v2, u_v1}, 3'b100);
        step(8'd1, 8'd2, 1'b1, 1'b1); check("er_rst",  {u_v3, u_v2, u_v1}, 3'b010);
        step(8'd1, 8'd2, 1'b1, 1'b0); check("er_post", {u_v3, u_v2, u_v1}, 3'b001);

        // randomized run against the reference model
        for (int k = 0; k < 1000; k++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
            check_both("rand");
            check("onehot_u", {2'b00, $onehot({u_v3, u_v2, u_v1})}, 3'b001);
            check("onehot_s", {2'b00, $onehot({s_v3, s_v2, s_v1})}, 3'b001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
